conv_frame_ctrl: RTL and testbench
==================================

// Module: conv_frame_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 streaming convolution datapath. Tracks pixel
//  column/row from the source pixel-valid strobe and gates the line-buffer
//  clock enable. Flags which outputs carry a full, non-wrapped 3x3 window.
//  Latches the kernel-select mode once per frame and reports frame completion.
//  Sits between the pixel source (camera/capture) and the convolution block.
// PARAMETERS
//  IMG_W  640            active pixels per line (>=3)
//  IMG_H  480            active lines per frame (>=3)
//  CW     $clog2(IMG_W)  column counter width
//  RW     $clog2(IMG_H)  row counter width
// PORTS
//  iCLK         in   1   clock
//  iRST         in   1   asynchronous reset, active-high
//  iSTART       in   1   frame-start pulse; arms sequencer, latches iMODE
//  iMODE        in   2   requested kernel (conv_ctrl_pkg::mode_t)
//  iDVAL        in   1   source pixel valid; one pixel accepted per high cycle
//  oLB_EN       out  1   line-buffer/convolution clock enable (combinational)
//  oMODE        out  2   kernel select held stable for the whole frame
//  oOUT_VLD     out  1   convolution output valid, any pixel of the frame
//  oWIN_VLD     out  1   output valid AND window fully inside the frame
//  oCOL         out  CW  column of the pixel accepted last cycle
//  oROW         out  RW  row of the pixel accepted last cycle
//  oBUSY        out  1   high in PRIME/ACTIVE
//  oFRAME_DONE  out  1   one-cycle pulse after the last pixel of the frame
//  oERR         out  1   sticky: iDVAL seen while IDLE/DONE; cleared by iSTART
// BEHAVIOUR
//  Reset: state IDLE; counters 0; oMODE=MODE_SOBEL_X; every registered output 0.
//  FSM states: IDLE, PRIME, ACTIVE, DONE.
//   IDLE  -> PRIME on iSTART (iMODE latched into oMODE, oERR cleared).
//   PRIME: rows 0..1, line buffers filling. -> ACTIVE on accepting (IMG_W-1, 1).
//   ACTIVE: rows 2..IMG_H-1. -> DONE on accepting (IMG_W-1, IMG_H-1).
//   DONE: one cycle, oFRAME_DONE=1. -> IDLE, or -> PRIME if iSTART is high.
//  Accept = iDVAL & (state in PRIME/ACTIVE, or iSTART while IDLE/DONE).
//   iSTART+iDVAL in same cycle: that pixel is (0,0).
//  oLB_EN = accept. Pure combinational, so the line buffer never shifts
//   outside a frame.
//  Counters advance only on accept. col wraps IMG_W-1 -> 0 and increments row.
//   row clears on the last pixel of the frame.
//  Output latency: 1 cycle after accept, aligned to the convolution's
//   registered output valid. oOUT_VLD, oCOL, oROW register the accepted
//   pixel's position.
//  oWIN_VLD = registered (accept & row>=2 & col>=2).
//   Window centre = (oROW-1, oCOL-1).
//  Gaps: iDVAL low mid-line freezes everything. No timeout.
//  iDVAL while IDLE/DONE without iSTART: pixel dropped, oLB_EN=0, oERR set.
//  iSTART while PRIME/ACTIVE: restart. Counters to 0, iMODE re-latched,
//   state PRIME, no oFRAME_DONE. A coincident iDVAL is accepted as (0,0).
//  oMODE changes only on an accepted iSTART. Never changes mid-frame.
//  Reset mid-frame: immediate return to the reset state. No oFRAME_DONE.
// STRUCTURE
//  conv_ctrl_pkg holds:
//   - state_t enum {IDLE, PRIME, ACTIVE, DONE}
//   - mode_t enum {MODE_SOBEL_X=0, MODE_SOBEL_Y=1, MODE_SMOOTH=2, MODE_PASS=3}
//   - KSIZE=3 and PRIME_ROWS=KSIZE-1 constants
//  Sub-module pixel_pos_counter (params W, H; ports clr, inc -> col, row,
//   last_col, last_pix) holds the wrap logic.
//  FSM and output registers stay in conv_frame_ctrl.
// TESTING  (IMG_W=4, IMG_H=4 unless noted)
//  1. iSTART, then 16 back-to-back iDVAL, iMODE=1 -> oLB_EN high 16 cycles;
//     oOUT_VLD 16 pulses; oWIN_VLD 4 pulses at (col,row)=(2,2),(3,2),(2,3),(3,3);
//     oFRAME_DONE one cycle after pixel 16; oMODE=1 throughout.
//  2. Same stream with iDVAL low every other cycle -> identical counts and
//     positions; oFRAME_DONE only after the 16th accepted pixel.
//  3. iDVAL x3 with no iSTART -> oLB_EN stays 0, oERR=1. Next iSTART clears
//     oERR, and the frame then runs as in test 1.
//  4. iSTART after 6 pixels, iMODE changed 0->2 -> no oFRAME_DONE; counters
//     restart at (0,0); oMODE=2; next 16 pixels give the test-1 pattern.
//  5. iRST asserted after pixel 9, iSTART after release -> all outputs 0
//     during reset; the following frame is clean.
//  6. iSTART+iDVAL together in DONE, IMG_W=5, IMG_H=3 -> that pixel is (0,0)
//     of frame 2; frame-2 oWIN_VLD count = 3.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the 3x3 convolution frame sequencer.
package conv_ctrl_pkg;
  localparam int KSIZE      = 3;
  localparam int PRIME_ROWS = KSIZE - 1;

  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE, DONE} state_t;

  typedef enum logic [1:0] {
    MODE_SOBEL_X = 2'd0,
    MODE_SOBEL_Y = 2'd1,
    MODE_SMOOTH  = 2'd2,
    MODE_PASS    = 2'd3
  } mode_t;
endpackage

// File: rtl/conv_frame_ctrl_pos.sv
// Column/row position counter with line and frame wrap.
module pixel_pos_counter #(
  parameter int W  = 640,
  parameter int H  = 480,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_pix_o
);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_col, last_row;

  assign last_col = (col_q == COL_MAX);
  assign last_row = (row_q == ROW_MAX);

  // A clear that coincides with an increment has consumed pixel (0,0).
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = inc_i ? CW'(1) : '0;
      row_d = '0;
    end else if (inc_i) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign last_col_o = last_col;
  assign last_pix_o = last_col & last_row;
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 streaming convolution: pixel accept, position,
// window-valid flagging, per-frame kernel mode and frame completion.
module conv_frame_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [1:0]    iMODE,
  input  logic          iDVAL,
  output logic          oLB_EN,
  output logic [1:0]    oMODE,
  output logic          oOUT_VLD,
  output logic          oWIN_VLD,
  output logic [CW-1:0] oCOL,
  output logic [RW-1:0] oROW,
  output logic          oBUSY,
  output logic          oFRAME_DONE,
  output logic          oERR
);
  state_t        state_q, state_d;
  mode_t         mode_q;
  logic          busy, accept, err_q, err_d;
  logic          out_vld_q, win_q;
  logic [CW-1:0] col_q, pos_col, pix_col;
  logic [RW-1:0] row_q, pos_row, pix_row;
  logic          last_col, last_pix, pix_last, prime_end, win_hit;

  assign busy   = (state_q == PRIME) || (state_q == ACTIVE);
  assign accept = iDVAL & (busy | iSTART);

  pixel_pos_counter #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_pos (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .clr_i      (iSTART),
    .inc_i      (accept),
    .col_o      (pos_col),
    .row_o      (pos_row),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  // A start pixel is always (0,0), whatever the counter currently holds.
  assign pix_col   = iSTART ? '0 : pos_col;
  assign pix_row   = iSTART ? '0 : pos_row;
  assign pix_last  = ~iSTART & last_pix;
  assign prime_end = ~iSTART & last_col & (pos_row == RW'(PRIME_ROWS - 1));
  assign win_hit   = (pix_row >= RW'(PRIME_ROWS)) && (pix_col >= CW'(KSIZE - 1));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (iSTART)             err_d = 1'b0;
    else if (iDVAL && !busy) err_d = 1'b1;
    case (state_q)
      IDLE:    if (iSTART) state_d = PRIME;
      PRIME:   if (iSTART) state_d = PRIME;
               else if (accept && prime_end) state_d = ACTIVE;
      ACTIVE:  if (iSTART) state_d = PRIME;
               else if (accept && pix_last) state_d = DONE;
      DONE:    state_d = iSTART ? PRIME : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SOBEL_X;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
      win_q     <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      out_vld_q <= accept;
      win_q     <= accept & win_hit;
      if (iSTART) mode_q <= mode_t'(iMODE);
      if (accept) begin
        col_q <= pix_col;
        row_q <= pix_row;
      end
    end
  end

  assign oLB_EN      = accept;
  assign oMODE       = mode_q;
  assign oOUT_VLD    = out_vld_q;
  assign oWIN_VLD    = win_q;
  assign oCOL        = col_q;
  assign oROW        = row_q;
  assign oBUSY       = busy;
  assign oFRAME_DONE = (state_q == DONE);
  assign oERR        = err_q;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: a 4x4 and a 5x3 instance share one stimulus
// stream and are both checked every cycle against a pixel-index model.
module tb_conv_frame_ctrl;
  logic       clk, rst, st, dv;
  logic [1:0] md;

  logic       lb0, vld0, win0, busy0, done0, err0;
  logic [1:0] mode0, col0, row0;
  logic       lb1, vld1, win1, busy1, done1, err1;
  logic [1:0] mode1, row1;
  logic [2:0] col1;

  conv_frame_ctrl #(.IMG_W(4), .IMG_H(4)) dut0 (
    .iCLK(clk), .iRST(rst), .iSTART(st), .iMODE(md), .iDVAL(dv),
    .oLB_EN(lb0), .oMODE(mode0), .oOUT_VLD(vld0), .oWIN_VLD(win0),
    .oCOL(col0), .oROW(row0), .oBUSY(busy0), .oFRAME_DONE(done0), .oERR(err0)
  );

  conv_frame_ctrl #(.IMG_W(5), .IMG_H(3)) dut1 (
    .iCLK(clk), .iRST(rst), .iSTART(st), .iMODE(md), .iDVAL(dv),
    .oLB_EN(lb1), .oMODE(mode1), .oOUT_VLD(vld1), .oWIN_VLD(win1),
    .oCOL(col1), .oROW(row1), .oBUSY(busy1), .oFRAME_DONE(done1), .oERR(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: in-frame flag, next pixel index, latched mode, sticky error
  int m_act[2], m_n[2], m_mode[2], m_err[2];
  int e_vld[2], e_win[2], e_col[2], e_row[2], e_done[2];
  int lb_cnt[2], vld_cnt[2], win_cnt[2], done_cnt[2];
  int winq[$];

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  task automatic step(input int k, input int lb, input int mo, input int vld,
                      input int win, input int col, input int row,
                      input int busy, input int done, input int err);
    int w, h, acc, pix;
    w = (k == 0) ? 4 : 5;
    h = (k == 0) ? 4 : 3;
    if (rst) begin
      m_act[k] = 0; m_n[k] = 0; m_mode[k] = 0; m_err[k] = 0;
      e_vld[k] = 0; e_win[k] = 0; e_col[k] = 0; e_row[k] = 0; e_done[k] = 0;
    end
    chk("busy", k, busy, m_act[k]);
    chk("frame_done", k, done, e_done[k]);
    chk("mode", k, mo, m_mode[k]);
    chk("err", k, err, m_err[k]);
    chk("out_vld", k, vld, e_vld[k]);
    chk("win_vld", k, win, e_win[k]);
    if (e_vld[k] != 0) begin
      chk("col", k, col, e_col[k]);
      chk("row", k, row, e_row[k]);
    end
    if (lb != 0)   lb_cnt[k]++;
    if (vld != 0)  vld_cnt[k]++;
    if (win != 0)  win_cnt[k]++;
    if (done != 0) done_cnt[k]++;
    if (k == 0 && win != 0) winq.push_back(row * 10 + col);
    if (rst) begin
      chk("lb_en_rst", k, lb, int'(dv & st));
    end else begin
      acc = (dv && (m_act[k] != 0 || st)) ? 1 : 0;
      chk("lb_en", k, lb, acc);
      pix = st ? 0 : m_n[k];
      e_vld[k]  = acc;
      e_win[k]  = (acc != 0 && (pix % w) >= 2 && (pix / w) >= 2) ? 1 : 0;
      e_done[k] = 0;
      if (acc != 0) begin
        e_col[k] = pix % w;
        e_row[k] = pix / w;
      end
      if (st) begin
        m_mode[k] = int'(md); m_err[k] = 0; m_act[k] = 1; m_n[k] = 0;
      end else if (dv && m_act[k] == 0) begin
        m_err[k] = 1;
      end
      if (acc != 0) begin
        if (pix == w * h - 1) begin
          m_act[k] = 0; e_done[k] = 1; m_n[k] = 0;
        end else begin
          m_n[k] = pix + 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    step(0, int'(lb0), int'(mode0), int'(vld0), int'(win0), int'(col0), int'(row0),
         int'(busy0), int'(done0), int'(err0));
    step(1, int'(lb1), int'(mode1), int'(vld1), int'(win1), int'(col1), int'(row1),
         int'(busy1), int'(done1), int'(err1));
  end

  task automatic drv(input logic s, input logic [1:0] m, input logic d);
    st = s; md = m; dv = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 2'd0, 1'b0);
  endtask

  task automatic clr_tally();
    for (int k = 0; k < 2; k++) begin
      lb_cnt[k] = 0; vld_cnt[k] = 0; win_cnt[k] = 0; done_cnt[k] = 0;
    end
    winq.delete();
  endtask

  task automatic pixels(input logic [1:0] m, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, m, 1'b1);
      if (gap) drv(1'b0, m, 1'b0);
    end
  endtask

  // hand-computed 4x4 frame signature: 16 pixels, windows at (2,2) (3,2) (2,3) (3,3)
  task automatic chk_frame4(input string nm, input int lb_exp);
    int ex[4];
    ex = '{22, 23, 32, 33};
    chk({nm, "_lb_cnt"}, 0, lb_cnt[0], lb_exp);
    chk({nm, "_vld_cnt"}, 0, vld_cnt[0], lb_exp);
    chk({nm, "_win_cnt"}, 0, win_cnt[0], 4);
    chk({nm, "_done_cnt"}, 0, done_cnt[0], 1);
    chk({nm, "_winq_n"}, 0, winq.size(), 4);
    if (winq.size() == 4)
      for (int i = 0; i < 4; i++) chk({nm, "_win_pos"}, 0, winq[i], ex[i]);
  endtask

  initial begin
    st = 1'b0; md = 2'd0; dv = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 0, int'(busy0), 0);
    chk("rst_mode", 0, int'(mode0), 0);
    chk("rst_vld", 0, int'(vld0), 0);
    chk("rst_err", 0, int'(err0), 0);
    rst = 1'b0;
    idle(1);

    // 1: back-to-back frame, mode 1
    clr_tally();
    drv(1'b1, 2'd1, 1'b0);
    pixels(2'd1, 16, 1'b0);
    idle(3);
    chk_frame4("t1", 16);
    chk("t1_mode", 0, int'(mode0), 1);

    // 2: same frame with a gap after every pixel
    clr_tally();
    drv(1'b1, 2'd1, 1'b0);
    pixels(2'd1, 16, 1'b1);
    idle(3);
    chk_frame4("t2", 16);

    // 3: pixels with no frame armed, then a clean frame
    clr_tally();
    pixels(2'd0, 3, 1'b0);
    chk("t3_lb_dropped", 0, lb_cnt[0], 0);
    chk("t3_err_set", 0, int'(err0), 1);
    idle(1);
    clr_tally();
    drv(1'b1, 2'd1, 1'b0);
    chk("t3_err_clr", 0, int'(err0), 0);
    pixels(2'd1, 16, 1'b0);
    idle(3);
    chk_frame4("t3", 16);

    // 4: restart after 6 pixels with a new mode
    clr_tally();
    drv(1'b1, 2'd0, 1'b0);
    pixels(2'd0, 6, 1'b0);
    drv(1'b1, 2'd2, 1'b0);
    chk("t4_mode", 0, int'(mode0), 2);
    chk("t4_busy", 0, int'(busy0), 1);
    drv(1'b0, 2'd2, 1'b1);
    chk("t4_first_col", 0, int'(col0), 0);
    chk("t4_first_row", 0, int'(row0), 0);
    chk("t4_no_done", 0, done_cnt[0], 0);
    pixels(2'd2, 15, 1'b0);
    idle(3);
    chk_frame4("t4", 22);

    // 5: reset mid-frame, then a clean frame
    drv(1'b1, 2'd3, 1'b0);
    pixels(2'd3, 9, 1'b0);
    rst = 1'b1;
    #2;
    chk("t5_busy", 0, int'(busy0), 0);
    chk("t5_vld", 0, int'(vld0), 0);
    chk("t5_mode", 0, int'(mode0), 0);
    chk("t5_done", 0, int'(done0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    clr_tally();
    drv(1'b1, 2'd1, 1'b0);
    pixels(2'd1, 16, 1'b0);
    idle(3);
    chk_frame4("t5", 16);

    // 6: start+pixel in the DONE cycle of the 5x3 instance
    clr_tally();
    drv(1'b1, 2'd2, 1'b0);
    pixels(2'd2, 15, 1'b0);
    drv(1'b1, 2'd1, 1'b1);
    chk("t6_vld", 1, int'(vld1), 1);
    chk("t6_col", 1, int'(col1), 0);
    chk("t6_row", 1, int'(row1), 0);
    chk("t6_mode", 1, int'(mode1), 1);
    chk("t6_done1", 1, done_cnt[1], 1);
    pixels(2'd1, 14, 1'b0);
    idle(3);
    chk("t6_win_cnt", 1, win_cnt[1], 6);
    chk("t6_done_cnt", 1, done_cnt[1], 2);
    chk("t6_lb_cnt", 1, lb_cnt[1], 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
